cic_ctrl: RTL and testbench

// - Sequencing controller in front of one CIC decimator (PDM mic path). Accepts a new (decimation, comb order) config,

---
 rtl/cic_pkg.sv | 24 ++
 rtl/cic_out_buf.sv | 43 ++++
 rtl/cic_ctrl.sv | 136 +++++++++++++
 tb/tb_cic_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared state encoding, width defaults and helpers for the CIC sequencing controller.
package cic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } cic_state_t;

    localparam int DEC_W_DEF        = 16;
    localparam int COMB_W_DEF       = 3;
    localparam int DATA_W_DEF       = 32;
    localparam int FLUSH_CYC_DEF    = 4;
    localparam int SETTLE_EXTRA_DEF = 1;

    localparam logic [7:0] OVF_MAX = 8'hFF;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cic_out_buf.sv
// One-entry valid/ready holding register for CIC samples; drops a new sample when full and
// not draining, counting drops in a saturating counter.
module cic_out_buf
    import cic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [7:0]        ovf_cnt
);

    logic can_take;

    // A full buffer frees up in the same cycle the consumer takes it.
    assign can_take = !m_valid || m_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            ovf_cnt <= '0;
        end else if (clr) begin
            m_valid <= 1'b0;
        end else if (load) begin
            if (can_take) begin
                m_valid <= 1'b1;
                m_data  <= load_data;
            end else if (ovf_cnt != OVF_MAX) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cic_ctrl.sv
// Sequencing controller in front of a CIC decimator: applies config under reset, discards settling
// outputs, then forwards samples. Define CIC_CTRL_SEQ_EN to add the m_seq sample index port.
//
// state  | meaning
// IDLE   | no config yet, CIC held in reset, config accepted
// FLUSH  | config latched, CIC held in reset for FLUSH_CYC cycles
// SETTLE | CIC running, settling strobes discarded
// RUN    | samples forwarded downstream, new config accepted
module cic_ctrl
    import cic_pkg::*;
#(
    parameter int DEC_W        = DEC_W_DEF,
    parameter int COMB_W       = COMB_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int FLUSH_CYC    = FLUSH_CYC_DEF,
    parameter int SETTLE_EXTRA = SETTLE_EXTRA_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DEC_W-1:0]  cfg_dec,
    input  logic [COMB_W-1:0] cfg_comb,
    output logic              cic_rst,
    output logic [DEC_W-1:0]  cic_dec_num,
    output logic [COMB_W-1:0] cic_comb_num,
    input  logic [DATA_W-1:0] cic_out,
    input  logic              cic_out_rdy,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic [7:0]        ovf_cnt
`ifdef CIC_CTRL_SEQ_EN
    ,
    output logic [15:0]       m_seq
`endif
);

    localparam int FL_W  = cnt_width(FLUSH_CYC - 1);
    localparam int SET_W = cnt_width((1 << COMB_W) - 1 + SETTLE_EXTRA);

    cic_state_t        state, state_nxt;
    logic [FL_W-1:0]   flush_cnt;
    logic [SET_W-1:0]  settle_cnt;
    logic              cfg_fire;
    logic              buf_load;

    assign cfg_fire = cfg_valid && cfg_ready;
    assign buf_load = cic_out_rdy && (state == ST_RUN) && !cfg_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        cic_rst   = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                cic_rst   = 1'b1;
                if (cfg_valid) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                cic_rst = 1'b1;
                busy    = 1'b1;
                if (flush_cnt == '0) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                // Leave on the strobe that is the last discard, so the next one is forwarded.
                if ((settle_cnt == '0) || (cic_out_rdy && (settle_cnt == SET_W'(1))))
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                cfg_ready = 1'b1;
                if (cfg_valid) state_nxt = ST_FLUSH;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cic_dec_num  <= '0;
            cic_comb_num <= '0;
            flush_cnt    <= '0;
            settle_cnt   <= '0;
        end else if (cfg_fire) begin
            cic_dec_num  <= (cfg_dec == '0) ? DEC_W'(1) : cfg_dec;
            cic_comb_num <= cfg_comb;
            flush_cnt    <= FL_W'(FLUSH_CYC - 1);
        end else if (state == ST_FLUSH) begin
            if (flush_cnt == '0)
                settle_cnt <= SET_W'(cic_comb_num) + SET_W'(SETTLE_EXTRA);
            else
                flush_cnt <= flush_cnt - FL_W'(1);
        end else if ((state == ST_SETTLE) && cic_out_rdy && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - SET_W'(1);
        end
    end

    cic_out_buf #(
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (cfg_fire),
        .load      (buf_load),
        .load_data (cic_out),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .ovf_cnt   (ovf_cnt)
    );

`ifdef CIC_CTRL_SEQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_seq <= '0;
        end else if (cfg_fire) begin
            m_seq <= '0;
        end else if (m_valid && m_ready) begin
            m_seq <= m_seq + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cic_ctrl.sv
// Directed bench for cic_ctrl: config sequencing, forwarding, drop counting, reconfig and reset.
module tb_cic_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_dec;
    logic [2:0]  cfg_comb;
    logic        cic_rst;
    logic [15:0] cic_dec_num;
    logic [2:0]  cic_comb_num;
    logic [31:0] cic_out;
    logic        cic_out_rdy;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        busy;
    logic [7:0]  ovf_cnt;
`ifdef CIC_CTRL_SEQ_EN
    logic [15:0] m_seq;
`endif

    int n_chk;
    int n_err;

    cic_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_dec      (cfg_dec),
        .cfg_comb     (cfg_comb),
        .cic_rst      (cic_rst),
        .cic_dec_num  (cic_dec_num),
        .cic_comb_num (cic_comb_num),
        .cic_out      (cic_out),
        .cic_out_rdy  (cic_out_rdy),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .busy         (busy),
        .ovf_cnt      (ovf_cnt)
`ifdef CIC_CTRL_SEQ_EN
        ,
        .m_seq        (m_seq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] d);
        cic_out     = d;
        cic_out_rdy = 1'b1;
        tick();
        cic_out_rdy = 1'b0;
    endtask

    task automatic offer_cfg(input logic [15:0] dec, input logic [2:0] comb);
        cfg_dec   = dec;
        cfg_comb  = comb;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        n_chk       = 0;
        n_err       = 0;
        rst         = 1'b0;
        cfg_valid   = 1'b0;
        cfg_dec     = '0;
        cfg_comb    = '0;
        cic_out     = '0;
        cic_out_rdy = 1'b0;
        m_ready     = 1'b0;
        #3;
        chk("rst_cic_rst", cic_rst, 1);
        chk("rst_dec", cic_dec_num, 0);
        chk("rst_comb", cic_comb_num, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf_cnt, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        tick();
        rst = 1'b1;
        tick();

        // Config from IDLE: dec=3 comb=4 -> 4 flush cycles, 5 discards.
        offer_cfg(16'd3, 3'd4);
        chk("cfg_dec", cic_dec_num, 3);
        chk("cfg_comb", cic_comb_num, 4);
        chk("flush_cfg_ready", cfg_ready, 0);
        n = 0;
        while (busy && cic_rst && n < 20) begin
            n++;
            tick();
        end
        chk("flush_len", n, 4);
        chk("settle_cic_rst", cic_rst, 0);
        chk("settle_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            strobe(32'hDEAD_0000 + i);
            if (i < 4) chk("settle_busy_mid", busy, 1);
        end
        chk("run_busy", busy, 0);
        chk("run_cfg_ready", cfg_ready, 1);
        chk("discard_no_valid", m_valid, 0);

        // RUN with m_ready=1: back-to-back strobes.
        m_ready = 1'b1;
        strobe(32'h10);
        chk("fwd0_valid", m_valid, 1);
        chk("fwd0_data", m_data, 32'h10);
`ifdef CIC_CTRL_SEQ_EN
        chk("seq0", m_seq, 0);
`endif
        strobe(32'h20);
        chk("fwd1_valid", m_valid, 1);
        chk("fwd1_data", m_data, 32'h20);
`ifdef CIC_CTRL_SEQ_EN
        chk("seq1", m_seq, 1);
`endif
        tick();
        chk("fwd_drained", m_valid, 0);
        chk("fwd_ovf", ovf_cnt, 0);

        // RUN with m_ready=0: hold first sample, count drops, saturate.
        m_ready = 1'b0;
        strobe(32'h31);
        strobe(32'h32);
        strobe(32'h33);
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, 32'h31);
        chk("hold_ovf2", ovf_cnt, 2);
        for (int i = 0; i < 300; i++) strobe(32'h100 + i);
        chk("ovf_sat", ovf_cnt, 255);
        chk("hold_data_sat", m_data, 32'h31);
`ifdef CIC_CTRL_SEQ_EN
        chk("seq2", m_seq, 2);
`endif
        m_ready = 1'b1;
        tick();
        chk("hold_drained", m_valid, 0);
        m_ready = 1'b0;
        strobe(32'h44);
        chk("pend_valid", m_valid, 1);
        chk("pend_data", m_data, 32'h44);

        // Reconfig in RUN with a pending sample; dec=0 clamps to 1.
        chk("run_ready_pre", cfg_ready, 1);
        offer_cfg(16'd0, 3'd1);
        chk("recfg_valid_clr", m_valid, 0);
        chk("recfg_busy", busy, 1);
        chk("recfg_cic_rst", cic_rst, 1);
        chk("recfg_ready", cfg_ready, 0);
        chk("recfg_dec_clamp", cic_dec_num, 1);
        chk("recfg_comb", cic_comb_num, 1);
        chk("recfg_ovf_kept", ovf_cnt, 255);
`ifdef CIC_CTRL_SEQ_EN
        chk("seq_reset", m_seq, 0);
`endif
        strobe(32'h55);
        chk("flush_strobe_ignored", m_valid, 0);
        n = 1;
        while (cic_rst && n < 20) begin
            n++;
            tick();
        end
        chk("reflush_len", n, 4);
        strobe(32'h66);
        chk("settle2_busy", busy, 1);
        chk("settle2_ready", cfg_ready, 0);
        chk("settle2_no_valid", m_valid, 0);

        // Async reset mid-SETTLE.
        #2;
        rst = 1'b0;
        #1;
        chk("arst_cic_rst", cic_rst, 1);
        chk("arst_busy", busy, 0);
        chk("arst_dec", cic_dec_num, 0);
        chk("arst_comb", cic_comb_num, 0);
        chk("arst_ovf", ovf_cnt, 0);
        chk("arst_ready", cfg_ready, 1);
        chk("arst_m_data", m_data, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_idle", cic_rst, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
